// File: rtl/counter_event_logger_pkg.sv
// counter_event_logger_pkg: event type encodings and record layout shared by the logger.
`default_nettype none

package counter_event_logger_pkg;

  localparam logic [1:0] EVT_NONE = 2'b00;
  localparam logic [1:0] EVT_RCO  = 2'b01;
  localparam logic [1:0] EVT_LOAD = 2'b10;
  localparam logic [1:0] EVT_BOTH = 2'b11;

  // Record = {header[7:0], ts}; offsets below are within the header byte.
  localparam int HDR_W        = 8;
  localparam int REC_TYPE_OFS = 6;
  localparam int REC_MODE_OFS = 4;
  localparam int REC_Q_OFS    = 0;

  function automatic logic [1:0] evt_type(input logic rco, input logic load);
    logic [1:0] t;
    case ({load, rco})
      2'b01:   t = EVT_RCO;
      2'b10:   t = EVT_LOAD;
      2'b11:   t = EVT_BOTH;
      default: t = EVT_NONE;
    endcase
    return t;
  endfunction

  function automatic logic [HDR_W-1:0] rec_hdr(input logic [1:0] typ,
                                               input logic [1:0] mode,
                                               input logic [3:0] q);
    logic [HDR_W-1:0] h;
    h = '0;
    h[REC_TYPE_OFS +: 2] = typ;
    h[REC_MODE_OFS +: 2] = mode;
    h[REC_Q_OFS    +: 4] = q;
    return h;
  endfunction

endpackage

`default_nettype wire

// File: rtl/event_fifo.sv
// event_fifo: show-ahead FIFO with registered wrap-bit pointers; a full push is accepted only alongside a pop.
`default_nettype none

module event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_do_pop;
  logic         w_do_push;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop frees a slot at the same edge, so a full FIFO still takes the push.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  assign dout = r_mem[r_rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/counter_event_logger.sv
// counter_event_logger: timestamps rco/load events from an upstream counter into a FIFO with drop tracking.
`default_nettype none

module counter_event_logger
  import counter_event_logger_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        Q,
  input  logic              rco,
  input  logic              load,
  input  logic [1:0]        mode,
  input  logic              log_en,
  input  logic              rd_ready,
  input  logic              clr_ovf,
  output logic              rd_valid,
  output logic [8+TS_W-1:0] rd_data,
  output logic              overflow,
  output logic [3:0]        drop_cnt
);

  localparam int REC_W = HDR_W + TS_W;

  logic [TS_W-1:0]  r_ts;
  logic             r_overflow;
  logic [3:0]       r_drop_cnt;
  logic             w_evt;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  logic [REC_W-1:0] w_rec;

  always_ff @(posedge clk) begin
    if (!reset) r_ts <= '0;
    else        r_ts <= r_ts + TS_W'(1);
  end

  assign w_evt = log_en & (rco | load);
  assign w_rec = {rec_hdr(evt_type(rco, load), mode, Q), r_ts};

  // Full FIFO loses the event unless the consumer pops at the same edge.
  assign w_drop = w_evt & w_full & ~rd_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_ovf)                r_drop_cnt <= 4'd1;
      else if (r_drop_cnt != 4'hF) r_drop_cnt <= r_drop_cnt + 4'd1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  event_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_evt),
    .pop   (rd_ready),
    .din   (w_rec),
    .dout  (rd_data),
    .full  (w_full),
    .empty (w_empty)
  );

  assign rd_valid = ~w_empty;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_counter_event_logger.sv
// tb_counter_event_logger: directed vector table plus hand sequences for wrap, saturation and clear priority.
`timescale 1ns/1ps
`default_nettype none

module tb_counter_event_logger;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  Q;
  logic        rco, load;
  logic [1:0]  mode;
  logic        log_en, rd_ready, clr_ovf;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        overflow;
  logic [3:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  counter_event_logger #(.DEPTH(4), .TS_W(8)) dut (
    .clk(clk), .reset(reset), .Q(Q), .rco(rco), .load(load), .mode(mode),
    .log_en(log_en), .rd_ready(rd_ready), .clr_ovf(clr_ovf),
    .rd_valid(rd_valid), .rd_data(rd_data), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic        rst_n, rco, load;
    logic [3:0]  q;
    logic [1:0]  mode;
    logic        en, rdy, clr;
    logic        exp_v;
    logic [15:0] exp_d;
    logic        exp_o;
    logic [3:0]  exp_c;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic rst_n, input logic r, input logic l,
                              input logic [3:0] q, input logic [1:0] m,
                              input logic en, input logic rdy, input logic clr,
                              input logic ev, input logic [15:0] ed,
                              input logic eo, input logic [3:0] ec);
    vec_t v;
    v.rst_n = rst_n; v.rco = r; v.load = l; v.q = q; v.mode = m;
    v.en = en; v.rdy = rdy; v.clr = clr;
    v.exp_v = ev; v.exp_d = ed; v.exp_o = eo; v.exp_c = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic r, input logic l, input logic [3:0] q,
                       input logic [1:0] m, input logic en, input logic rdy, input logic clr);
    reset = rst_n; rco = r; load = l; Q = q; mode = m;
    log_en = en; rd_ready = rdy; clr_ovf = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1, 0, 0, 4'h0, 2'b00, 1, 0, 0);
    repeat (n) step();
  endtask

  initial begin
    drive(0, 0, 0, 4'h0, 2'b00, 1, 0, 0);

    // reset, then ts=1..4 idle
    vt.push_back(mk(0,0,0,4'h0,2'd0,1,0,0, 0,16'h0000,0,4'd0));
    for (int i = 0; i < 5; i++) vt.push_back(mk(1,0,0,4'h0,2'd0,1,0,0, 0,16'h0000,0,4'd0));
    // ts=5 rco, Q=F, mode=0
    vt.push_back(mk(1,1,0,4'hF,2'd0,1,0,0, 1,16'h4F05,0,4'd0));
    // ts=6 rco+load, Q=3, mode=3
    vt.push_back(mk(1,1,1,4'h3,2'd3,1,0,0, 1,16'h4F05,0,4'd0));
    vt.push_back(mk(1,0,0,4'h0,2'd0,1,1,0, 1,16'hF306,0,4'd0));
    // ts=8 push+pop with one record held
    vt.push_back(mk(1,0,1,4'hA,2'd1,1,1,0, 1,16'h9A08,0,4'd0));
    // ts=9 event with log_en=0 ignored
    vt.push_back(mk(1,1,0,4'h1,2'd0,0,0,0, 1,16'h9A08,0,4'd0));
    vt.push_back(mk(1,0,0,4'h0,2'd0,1,1,0, 0,16'h0000,0,4'd0));
    vt.push_back(mk(1,0,0,4'h0,2'd0,1,1,0, 0,16'h0000,0,4'd0));
    // ts=12..17: six events, rd_ready=0
    vt.push_back(mk(1,1,0,4'h1,2'd2,1,0,0, 1,16'h610C,0,4'd0));
    vt.push_back(mk(1,1,0,4'h2,2'd2,1,0,0, 1,16'h610C,0,4'd0));
    vt.push_back(mk(1,1,0,4'h3,2'd2,1,0,0, 1,16'h610C,0,4'd0));
    vt.push_back(mk(1,1,0,4'h4,2'd2,1,0,0, 1,16'h610C,0,4'd0));
    vt.push_back(mk(1,1,0,4'h5,2'd2,1,0,0, 1,16'h610C,1,4'd1));
    vt.push_back(mk(1,1,0,4'h6,2'd2,1,0,0, 1,16'h610C,1,4'd2));
    // ts=18: full, event plus pop -> no drop
    vt.push_back(mk(1,1,0,4'h7,2'd2,1,1,0, 1,16'h620D,1,4'd2));
    vt.push_back(mk(1,0,0,4'h0,2'd0,1,1,0, 1,16'h630E,1,4'd2));
    vt.push_back(mk(1,0,0,4'h0,2'd0,1,1,0, 1,16'h640F,1,4'd2));
    vt.push_back(mk(1,0,0,4'h0,2'd0,1,1,0, 1,16'h6712,1,4'd2));
    vt.push_back(mk(1,0,0,4'h0,2'd0,1,1,0, 0,16'h0000,1,4'd2));
    vt.push_back(mk(1,0,0,4'h0,2'd0,1,0,1, 0,16'h0000,0,4'd0));
    // ts=24..28: fill, then one drop
    vt.push_back(mk(1,1,0,4'h1,2'd0,1,0,0, 1,16'h4118,0,4'd0));
    vt.push_back(mk(1,1,0,4'h2,2'd0,1,0,0, 1,16'h4118,0,4'd0));
    vt.push_back(mk(1,1,0,4'h3,2'd0,1,0,0, 1,16'h4118,0,4'd0));
    vt.push_back(mk(1,1,0,4'h4,2'd0,1,0,0, 1,16'h4118,0,4'd0));
    vt.push_back(mk(1,1,0,4'h5,2'd0,1,0,0, 1,16'h4118,1,4'd1));
    // mid-run reset with a coincident event flushes everything
    vt.push_back(mk(0,1,0,4'h6,2'd0,1,0,0, 0,16'h0000,0,4'd0));
    // first edge after release carries ts=0
    vt.push_back(mk(1,1,0,4'h5,2'd1,1,0,0, 1,16'h5500,0,4'd0));
    vt.push_back(mk(1,0,0,4'h0,2'd0,1,1,0, 0,16'h0000,0,4'd0));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst_n, vt[i].rco, vt[i].load, vt[i].q, vt[i].mode,
            vt[i].en, vt[i].rdy, vt[i].clr);
      step();
      chk($sformatf("v%0d.valid", i), {15'd0, rd_valid}, {15'd0, vt[i].exp_v});
      if (vt[i].exp_v) chk($sformatf("v%0d.data", i), rd_data, vt[i].exp_d);
      chk($sformatf("v%0d.ovf", i), {15'd0, overflow}, {15'd0, vt[i].exp_o});
      chk($sformatf("v%0d.cnt", i), {12'd0, drop_cnt}, {12'd0, vt[i].exp_c});
    end

    // ts is now 2; advance so the next edge samples ts=255
    idle(253);
    drive(1, 1, 0, 4'h9, 2'b00, 1, 0, 0); step();
    chk("wrap.ts255", rd_data, 16'h49FF);
    drive(1, 0, 1, 4'h8, 2'b00, 1, 0, 0); step();
    chk("wrap.hold", rd_data, 16'h49FF);
    drive(1, 1, 0, 4'h1, 2'b00, 1, 0, 0); step();
    drive(1, 1, 0, 4'h1, 2'b00, 1, 0, 0); step();
    chk("full.nodrop", {12'd0, drop_cnt}, 16'd0);

    // saturation: 15 drops reach 15, further drops stay there
    drive(1, 1, 0, 4'h2, 2'b00, 1, 0, 0);
    repeat (15) step();
    chk("sat.15", {12'd0, drop_cnt}, 16'd15);
    repeat (3) step();
    chk("sat.hold", {12'd0, drop_cnt}, 16'd15);
    chk("sat.ovf", {15'd0, overflow}, 16'd1);

    // clear coincident with a drop: drop wins
    drive(1, 1, 0, 4'h2, 2'b00, 1, 0, 1); step();
    chk("clrdrop.cnt", {12'd0, drop_cnt}, 16'd1);
    chk("clrdrop.ovf", {15'd0, overflow}, 16'd1);
    drive(1, 0, 0, 4'h0, 2'b00, 1, 0, 1); step();
    chk("clr.cnt", {12'd0, drop_cnt}, 16'd0);
    chk("clr.ovf", {15'd0, overflow}, 16'd0);

    // drain: wrapped timestamps in arrival order
    chk("drain.0", rd_data, 16'h49FF);
    drive(1, 0, 0, 4'h0, 2'b00, 1, 1, 0); step();
    chk("drain.1", rd_data, 16'h8800);
    step();
    chk("drain.2", rd_data, 16'h4101);
    step();
    chk("drain.3", rd_data, 16'h4102);
    step();
    chk("drain.empty", {15'd0, rd_valid}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
